mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: word-aligned memory cycles, RMW sub-word stores, load extension
module mem_access_unit #(
    parameter int len_data  = 32,
    parameter int ram_depth = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_wr,
    input  logic [1:0]                        req_size,
    input  logic                              req_unsigned,
    input  logic [31:0]                       req_addr,
    input  logic [len_data-1:0]               req_wdata,
    output logic                              rsp_valid,
    output logic                              rsp_err,
    output logic [len_data-1:0]               rsp_rdata,
    output logic [clogb2(ram_depth-1)-1:0]    mem_addr,
    output logic [len_data-1:0]               mem_wdata,
    output logic                              mem_rd,
    output logic                              mem_wr,
    input  logic [len_data-1:0]               mem_rdata
);

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    localparam int AW = clogb2(ram_depth - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LATCH, S_WR, S_RESP} state_t;

    state_t      state;
    logic        cap_wr;
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic [1:0]  cap_off;
    logic [15:0] cap_wdata;

    logic                req_err;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [len_data-1:0] load_ext;
    logic [len_data-1:0] merged;

    // Upper address bits fall outside the memory and simply wrap.
    wire unused_addr = &{1'b0, req_addr[31:AW+2]};

    assign req_ready = (state == S_IDLE);

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (cap_off)
            2'd0:    byte_sel = mem_rdata[31:24];
            2'd1:    byte_sel = mem_rdata[23:16];
            2'd2:    byte_sel = mem_rdata[15:8];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = cap_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        case (cap_size)
            2'b00:   load_ext = {{24{byte_sel[7] & ~cap_uns}}, byte_sel};
            2'b01:   load_ext = {{16{half_sel[15] & ~cap_uns}}, half_sel};
            default: load_ext = mem_rdata;
        endcase

        merged = mem_rdata;
        if (cap_size == 2'b00) begin
            case (cap_off)
                2'd0:    merged[31:24] = cap_wdata[7:0];
                2'd1:    merged[23:16] = cap_wdata[7:0];
                2'd2:    merged[15:8]  = cap_wdata[7:0];
                default: merged[7:0]   = cap_wdata[7:0];
            endcase
        end else if (cap_off[1]) begin
            merged[15:0] = cap_wdata;
        end else begin
            merged[31:16] = cap_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cap_wr    <= 1'b0;
            cap_size  <= 2'b00;
            cap_uns   <= 1'b0;
            cap_off   <= 2'b00;
            cap_wdata <= 16'h0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_wr    <= req_wr;
                        cap_size  <= req_size;
                        cap_uns   <= req_unsigned;
                        cap_off   <= req_addr[1:0];
                        cap_wdata <= req_wdata[15:0];
                        mem_addr  <= req_addr[AW+1:2];
                        if (req_err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_wr && req_size == 2'b10) begin
                            state     <= S_WR;
                            mem_wr    <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state  <= S_RD;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                S_RD: state <= S_LATCH;
                S_LATCH: begin
                    if (cap_wr) begin
                        state     <= S_WR;
                        mem_wr    <= 1'b1;
                        mem_wdata <= merged;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_ext;
                    end
                end
                S_WR: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    rsp_err <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a queue-based transaction model
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    mem_access_unit #(.len_data(32), .ram_depth(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: synchronous read, write on the falling edge.
    logic [31:0] mem [64];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
    always @(negedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_wr   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One expected-output record per cycle following the accept edge.
    typedef struct {
        logic        rd, wr, rv, err;
        logic [5:0]  addr;
        logic [31:0] wdata, rdata;
    } cyc_t;

    cyc_t        q[$];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_rdata;
    bit          manual;
    logic [31:0] obs_rdata, obs_wdata;
    logic        obs_err;

    function automatic cyc_t blank(input logic [5:0] a);
        cyc_t c;
        c.rd = 0; c.wr = 0; c.rv = 0; c.err = 0;
        c.addr = a; c.wdata = 0; c.rdata = 0;
        return c;
    endfunction

    task automatic model_req(input logic wr, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int          wi, sh;
        logic [1:0]  off;
        logic [31:0] w, v, mask;
        cyc_t        c;
        bit          err;
        wi  = int'(addr[7:2]);
        off = addr[1:0];
        w   = ref_mem[wi];
        err = (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
        if (err) begin
            c = blank(6'(wi)); c.rv = 1; c.err = 1; c.rdata = exp_rdata; q.push_back(c);
        end else if (!wr) begin
            if (size == 2'd0) begin
                sh = 8 * (3 - int'(off));
                v  = (w >> sh) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 2'd1) begin
                sh = 8 * (2 - int'(off));
                v  = (w >> sh) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
            exp_rdata = v;
            c = blank(6'(wi)); c.rd = 1; q.push_back(c);
            c = blank(6'(wi)); q.push_back(c);
            c = blank(6'(wi)); c.rv = 1; c.rdata = v; q.push_back(c);
        end else begin
            if (size == 2'd2) begin
                v = wdata;
            end else begin
                if (size == 2'd0) begin
                    sh = 8 * (3 - int'(off)); mask = 32'hFF << sh;
                end else begin
                    sh = 8 * (2 - int'(off)); mask = 32'hFFFF << sh;
                end
                v = (w & ~mask) | ((wdata << sh) & mask);
                c = blank(6'(wi)); c.rd = 1; q.push_back(c);
                c = blank(6'(wi)); q.push_back(c);
            end
            ref_mem[wi] = v;
            c = blank(6'(wi)); c.wr = 1; c.wdata = v; q.push_back(c);
            c = blank(6'(wi)); c.rv = 1; c.rdata = exp_rdata; q.push_back(c);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr) n_wr++;
        if (rst_n && !manual) begin
            if (q.size() == 0) begin
                check("idle_ready", 32'(req_ready), 32'd1);
                check("idle_rd",    32'(mem_rd),    32'd0);
                check("idle_wr",    32'(mem_wr),    32'd0);
                check("idle_rv",    32'(rsp_valid), 32'd0);
            end else begin
                cyc_t c;
                c = q.pop_front();
                check("ready",     32'(req_ready), 32'd0);
                check("mem_rd",    32'(mem_rd),    32'(c.rd));
                check("mem_wr",    32'(mem_wr),    32'(c.wr));
                check("rsp_valid", 32'(rsp_valid), 32'(c.rv));
                if (c.rd || c.wr) check("mem_addr", 32'(mem_addr), 32'(c.addr));
                if (c.wr) begin
                    check("mem_wdata", mem_wdata, c.wdata);
                    obs_wdata = mem_wdata;
                end
                if (c.rv) begin
                    check("rsp_err",   32'(rsp_err), 32'(c.err));
                    check("rsp_rdata", rsp_rdata,    c.rdata);
                    obs_rdata = rsp_rdata;
                    obs_err   = rsp_err;
                end
            end
        end
    end

    // kind: 0 none, 1 load data, 2 written word, 3 error flag
    task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int kind, input logic [31:0] lit);
        int n;
        #1;
        req_valid = 1; req_wr = wr; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 0; req_wr = 0; req_size = 2'd3; req_addr = 32'hFFFF_FFFF;
        model_req(wr, size, uns, addr, wdata);
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout: %0d records left, required 0", q.size());
            q.delete();
        end
        check("mem_word", mem[addr[7:2]], ref_mem[addr[7:2]]);
        case (kind)
            1: check("lit_rdata", obs_rdata, lit);
            2: check("lit_wdata", obs_wdata, lit);
            3: check("lit_err",   32'(obs_err), lit);
            default: ;
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wr0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0; ref_mem[i] = 32'h0;
        end
        mem_rdata = 0; exp_rdata = 0; manual = 0;
        obs_rdata = 0; obs_wdata = 0; obs_err = 0;
        rst_n = 0; req_valid = 0; req_wr = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rv",    32'(rsp_valid), 32'd0);
        check("rst_err",   32'(rsp_err),   32'd0);
        check("rst_rdata", rsp_rdata,      32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_wdata", mem_wdata,      32'd0);
        check("rst_rd",    32'(mem_rd),    32'd0);
        check("rst_wr",    32'(mem_wr),    32'd0);
        rst_n = 1;
        @(posedge clk);

        do_req(1, 2'd2, 0, 32'h10, 32'h1122_3344, 2, 32'h1122_3344);
        do_req(0, 2'd2, 0, 32'h10, 32'h0,         1, 32'h1122_3344);
        do_req(1, 2'd0, 0, 32'h13, 32'h0000_009A, 2, 32'h1122_339A);
        do_req(0, 2'd0, 0, 32'h13, 32'h0,         1, 32'hFFFF_FF9A);
        do_req(0, 2'd0, 1, 32'h13, 32'h0,         1, 32'h0000_009A);
        do_req(1, 2'd1, 0, 32'h10, 32'h0000_BEEF, 2, 32'hBEEF_339A);
        do_req(0, 2'd1, 0, 32'h10, 32'h0,         1, 32'hFFFF_BEEF);
        do_req(0, 2'd1, 1, 32'h12, 32'h0,         1, 32'h0000_339A);
        do_req(0, 2'd2, 0, 32'h11, 32'h0,         3, 32'd1);
        do_req(1, 2'd1, 0, 32'h13, 32'h0000_1234, 3, 32'd1);
        do_req(0, 2'd3, 0, 32'h10, 32'h0,         3, 32'd1);
        do_req(0, 2'd2, 0, 32'h10, 32'h0,         1, 32'hBEEF_339A);
        do_req(1, 2'd2, 0, 32'h110, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);
        do_req(0, 2'd2, 0, 32'h010, 32'h0,         1, 32'hCAFE_F00D);
        do_req(0, 2'd0, 0, 32'h11, 32'h0,          1, 32'hFFFF_FFFE);
        do_req(1, 2'd0, 0, 32'h3F, 32'h0000_0077,  2, 32'h0000_0077);
        do_req(0, 2'd1, 1, 32'h12, 32'h0,          1, 32'h0000_F00D);

        // Reset asserted while an SB sits in its read-latch cycle.
        manual = 1;
        #1;
        req_valid = 1; req_wr = 1; req_size = 2'd0; req_unsigned = 0;
        req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 0;
        wr0 = n_wr;
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_rd",    32'(mem_rd),    32'd0);
        check("abort_wr",    32'(mem_wr),    32'd0);
        check("abort_rv",    32'(rsp_valid), 32'd0);
        check("abort_err",   32'(rsp_err),   32'd0);
        check("abort_rdata", rsp_rdata,      32'd0);
        check("abort_addr",  32'(mem_addr),  32'd0);
        check("abort_wdata", mem_wdata,      32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1;
        @(posedge clk);
        #1;
        check("abort_ready_after", 32'(req_ready), 32'd1);
        check("abort_no_write",    32'(n_wr),      32'(wr0));
        check("abort_mem",         mem[4],         32'hCAFE_F00D);
        exp_rdata = 0;
        manual = 0;
        @(posedge clk);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 1, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
